fft_8_frame_ctrl: RTL and testbench
===================================

Name: fft_8_frame_ctrl

Overview:
- Host-side driver for the 8-point FFT core's start/done interface. It plays the role the bench plays today, but as synthesizable RTL.
- Collects 8 complex samples from a valid/ready input stream, presents them as a parallel frame, pulses start and waits for done. It then captures the 8 results and streams them out on a valid/ready output.
- Sits between the sample source and fft_8_sol1_gen1. It is single-buffered: load, compute and unload never overlap.

Parameters:
- DATA_W, 16, width of each real/imag component.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before the frame is abandoned (must be >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  input sample valid
- s_ready  output  1  input sample ready
- s_real  input  DATA_W  input sample real part
- s_imag  input  DATA_W  input sample imag part
- fft_start  output  1  one-cycle start pulse to the FFT core
- fft_in_real  output  8*DATA_W  frame real parts; element i at [DATA_W*i +: DATA_W]
- fft_in_imag  output  8*DATA_W  frame imag parts, same packing
- fft_done  input  1  FFT core completion
- fft_out_real  input  8*DATA_W  FFT result real parts, same packing
- fft_out_imag  input  8*DATA_W  FFT result imag parts, same packing
- m_valid  output  1  output beat valid
- m_ready  input  1  output beat ready
- m_real  output  DATA_W  output beat real part
- m_imag  output  DATA_W  output beat imag part
- m_index  output  3  bin index of the current beat
- m_last  output  1  high on the beat with index 7
- busy  output  1  high in START, WAIT and UNLOAD
- timeout_err  output  1  sticky; set on timeout, cleared only by rst

Behaviour:
- States: LOAD, START, WAIT, UNLOAD.
- Reset (synchronous, wins over all other events):
  - state goes to LOAD; all counters go to 0.
  - Frame and result registers go to 0.
  - fft_start, m_valid, busy, timeout_err and m_index go to 0; m_last goes to 0.
  - s_ready is 1 on the first cycle after rst deasserts.
  - A partially loaded or in-flight frame is discarded.
  - A late fft_done arriving after reset is ignored, because the block is in LOAD.
- LOAD:
  - s_ready = 1.
  - On s_valid && s_ready, the sample is written to slot wr_idx, and wr_idx increments.
  - Bubbles (s_valid = 0) hold wr_idx.
  - Accepting slot 7 moves the block to START on the next cycle and resets wr_idx to 0.
- START:
  - fft_start = 1 for exactly this one cycle; s_ready = 0.
  - Moves to WAIT unconditionally.
  - fft_done during START is ignored.
- WAIT:
  - A wait counter starts at 0 on entry and increments each cycle.
  - If fft_done = 1, fft_out_real/imag are latched into the result registers, and the next state is UNLOAD.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES-1, timeout_err is set, the next state is LOAD, and the frame is dropped.
  - If done arrives in the same cycle as the timeout, done wins and no error is flagged.
- UNLOAD:
  - m_valid = 1.
  - m_real/m_imag show result slot rd_idx; m_index = rd_idx; m_last = (rd_idx == 7).
  - On m_valid && m_ready, rd_idx increments.
  - The handshake on index 7 moves the block to LOAD, resets rd_idx to 0, and drops m_valid on the next cycle.
  - While m_ready = 0, all m_* outputs hold stable.
- fft_in_real/imag are driven directly from the frame registers. They are stable from the START cycle until the next LOAD write.
- Latency:
  - Slot 7 accepted at cycle T gives fft_start at T+1.
  - fft_done sampled at cycle D gives the first m_valid at D+1.
  - Full throughput is 8 output beats in 8 cycles when m_ready is held at 1.
- No arithmetic is performed. Data passes through bit-exact, with no width change.

Test Plan:
- Impulse frame: feed s_real = 0x0100 at slot 0 and 0 elsewhere, all imag 0. Use a stub core that asserts done 5 cycles after start and returns all-0x0100 real.
  - Required: fft_start high exactly one cycle, at T+1.
  - Required: fft_in_real[15:0] = 0x0100 and the rest 0.
  - Required: 8 beats of 0x0100/0x0000, m_index 0..7, m_last only on beat 7.
- Input bubbles: s_valid pattern 1,0,1,1,0,... with samples 0x0001..0x0008.
  - Required: slots hold 0x0001..0x0008 in order.
  - Required: fft_start only after the 8th accept; s_ready = 0 from START onward.
- Output backpressure: stub returns 0x0010..0x0080; m_ready toggles 1,0,1,0,...
  - Required: exactly 8 accepted beats in order, no repeats or skips.
  - Required: outputs unchanged across every stalled cycle.
- Timeout: TIMEOUT_CYCLES = 16 and the stub never asserts done.
  - Required: timeout_err rises 16 cycles after WAIT entry and stays high.
  - Required: s_ready = 1 on the next cycle; m_valid is never asserted.
  - Required: a following good frame completes normally while timeout_err remains 1.
- Reset mid-load: assert rst for 1 cycle after 5 accepted samples, then send a full 8-sample frame.
  - Required: no fft_start from the partial frame.
  - Required: the new frame occupies slots 0..7 and processes correctly.
- Back-to-back frames: send frame A, then immediately frame B with s_valid held at 1.
  - Required: s_ready stays 0 until A's index-7 beat is accepted.
  - Required: B's results stream correctly afterwards; there are exactly two fft_start pulses.

Source files
------------

// File: rtl/fft_8_frame_ctrl.sv
// Host-side frame controller for the 8-point FFT core.
// It gathers 8 input samples, starts the core, waits for done, then streams out the 8 results.
module fft_8_frame_ctrl #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_real,
    input  logic [DATA_W-1:0]   s_imag,
    output logic                fft_start,
    output logic [8*DATA_W-1:0] fft_in_real,
    output logic [8*DATA_W-1:0] fft_in_imag,
    input  logic                fft_done,
    input  logic [8*DATA_W-1:0] fft_out_real,
    input  logic [8*DATA_W-1:0] fft_out_imag,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_real,
    output logic [DATA_W-1:0]   m_imag,
    output logic [2:0]          m_index,
    output logic                m_last,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t state, next_state;

    logic [DATA_W-1:0] frame_real  [8];
    logic [DATA_W-1:0] frame_imag  [8];
    logic [DATA_W-1:0] result_real [8];
    logic [DATA_W-1:0] result_imag [8];
    logic [2:0]        wr_idx;
    logic [2:0]        rd_idx;
    logic [CNT_W-1:0]  wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // done takes priority over the timeout when both land in the same WAIT cycle
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:    if (s_valid && wr_idx == 3'd7) next_state = START;
            START:   next_state = WAIT;
            WAIT: begin
                if (fft_done) begin
                    next_state = UNLOAD;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = LOAD;
                end
            end
            UNLOAD:  if (m_ready && rd_idx == 3'd7) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        s_ready   = (state == LOAD);
        fft_start = (state == START);
        m_valid   = (state == UNLOAD);
        busy      = (state != LOAD);
        m_last    = (state == UNLOAD) && (rd_idx == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx      <= 3'd0;
            rd_idx      <= 3'd0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                frame_real[i]  <= '0;
                frame_imag[i]  <= '0;
                result_real[i] <= '0;
                result_imag[i] <= '0;
            end
        end else begin
            // wr_idx wraps from 7 back to 0 as the last slot is accepted
            if (state == LOAD && s_valid) begin
                frame_real[wr_idx] <= s_real;
                frame_imag[wr_idx] <= s_imag;
                wr_idx             <= wr_idx + 3'd1;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if (state == WAIT && fft_done) begin
                for (int i = 0; i < 8; i++) begin
                    result_real[i] <= fft_out_real[DATA_W*i +: DATA_W];
                    result_imag[i] <= fft_out_imag[DATA_W*i +: DATA_W];
                end
            end
            if (state == WAIT && !fft_done && wait_cnt == WAIT_LAST) begin
                timeout_err <= 1'b1;
            end
            if (state == UNLOAD && m_ready) begin
                rd_idx <= rd_idx + 3'd1;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign fft_in_real[DATA_W*g +: DATA_W] = frame_real[g];
        assign fft_in_imag[DATA_W*g +: DATA_W] = frame_imag[g];
    end

    assign m_real  = result_real[rd_idx];
    assign m_imag  = result_imag[rd_idx];
    assign m_index = rd_idx;

endmodule

// File: tb/tb_fft_8_frame_ctrl.sv
// Directed bench for fft_8_frame_ctrl with a stub FFT core that raises done 5 cycles after start.
module tb_fft_8_frame_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_real;
    logic [15:0]  s_imag;
    logic         fft_start;
    logic [127:0] fft_in_real;
    logic [127:0] fft_in_imag;
    logic         fft_done;
    logic [127:0] fft_out_real;
    logic [127:0] fft_out_imag;
    logic         m_valid;
    logic         m_ready;
    logic [15:0]  m_real;
    logic [15:0]  m_imag;
    logic [2:0]   m_index;
    logic         m_last;
    logic         busy;
    logic         timeout_err;

    logic [15:0] tx_real [8];
    logic [15:0] tx_imag [8];
    logic [15:0] stub_real [8];
    logic [15:0] stub_imag [8];
    logic        stub_en;
    logic [2:0]  stub_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_count = 0;

    fft_8_frame_ctrl #(.DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
        .fft_start(fft_start), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
        .fft_done(fft_done), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .m_index(m_index), .m_last(m_last), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fft_start) start_count <= start_count + 1;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            fft_out_real[16*i +: 16] = stub_real[i];
            fft_out_imag[16*i +: 16] = stub_imag[i];
        end
    end

    // stub core: start seen at cycle S gives done high during cycle S+5
    always @(posedge clk) begin
        if (rst) begin
            stub_cnt <= 3'd0;
            fft_done <= 1'b0;
        end else begin
            fft_done <= 1'b0;
            if (fft_start && stub_en) begin
                stub_cnt <= 3'd4;
            end else if (stub_cnt != 3'd0) begin
                stub_cnt <= stub_cnt - 3'd1;
                if (stub_cnt == 3'd1) fft_done <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_frame(input logic [15:0] a [8]);
        logic [127:0] p;
        for (int i = 0; i < 8; i++) p[16*i +: 16] = a[i];
        return p;
    endfunction

    // leaves the bench in the cycle after the last accept (START for a full frame)
    task automatic send_frame(input int nslots, input bit bubbles, output int t_last);
        int slot = 0;
        int k = 0;
        bit acc;
        t_last = -1;
        while (slot < nslots && k < 200) begin
            s_valid = bubbles ? ((k % 5) != 1 && (k % 5) != 4) : 1'b1;
            s_real  = tx_real[slot];
            s_imag  = tx_imag[slot];
            acc = s_valid && s_ready;
            if (acc && slot == 7) t_last = cyc;
            tick();
            if (acc) slot++;
            k++;
        end
        s_valid = 1'b0;
        check_output("load_accepts", 128'(slot), 128'(nslots));
    endtask

    task automatic check_start();
        check_output("start_high", 128'(fft_start), 128'd1);
        check_output("start_sready", 128'(s_ready), 128'd0);
        check_output("start_busy", 128'(busy), 128'd1);
        check_output("frame_real", fft_in_real, pack_frame(tx_real));
        check_output("frame_imag", fft_in_imag, pack_frame(tx_imag));
        tick();
        check_output("start_one_cycle", 128'(fft_start), 128'd0);
    endtask

    task automatic recv_frame(input bit toggle, input bit hold_sready0, output int first_valid);
        int n = 0;
        int k = 0;
        bit hs;
        while (!m_valid && k < 50) begin
            if (hold_sready0) check_output("wait_sready", 128'(s_ready), 128'd0);
            tick();
            k++;
        end
        first_valid = cyc;
        check_output("mvalid_seen", 128'(m_valid), 128'd1);
        k = 0;
        while (n < 8 && k < 100) begin
            m_ready = toggle ? ((k % 2) == 0) : 1'b1;
            check_output("beat_valid", 128'(m_valid), 128'd1);
            check_output("beat_real", 128'(m_real), 128'(stub_real[n]));
            check_output("beat_imag", 128'(m_imag), 128'(stub_imag[n]));
            check_output("beat_index", 128'(m_index), 128'(n));
            check_output("beat_last", 128'(m_last), 128'(n == 7));
            if (hold_sready0) check_output("unload_sready", 128'(s_ready), 128'd0);
            hs = m_ready && m_valid;
            tick();
            if (hs) n++;
            k++;
        end
        m_ready = 1'b0;
        check_output("beat_count", 128'(n), 128'd8);
        check_output("post_mvalid", 128'(m_valid), 128'd0);
        check_output("post_busy", 128'(busy), 128'd0);
        check_output("post_sready", 128'(s_ready), 128'd1);
    endtask

    initial begin
        int t_last, fv, s0;
        rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; m_ready = 1'b0; stub_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = '0; tx_imag[i] = '0; stub_real[i] = '0; stub_imag[i] = '0;
        end
        tick();
        tick();
        check_output("rst_start", 128'(fft_start), 128'd0);
        check_output("rst_mvalid", 128'(m_valid), 128'd0);
        check_output("rst_busy", 128'(busy), 128'd0);
        check_output("rst_terr", 128'(timeout_err), 128'd0);
        check_output("rst_index", 128'(m_index), 128'd0);
        check_output("rst_last", 128'(m_last), 128'd0);
        check_output("rst_frame", fft_in_real, 128'd0);
        rst = 1'b0;
        check_output("rst_sready", 128'(s_ready), 128'd1);

        $display("[TB] impulse frame");
        tx_real[0] = 16'h0100;
        for (int i = 0; i < 8; i++) stub_real[i] = 16'h0100;
        send_frame(8, 1'b0, t_last);
        s0 = cyc;
        check_output("imp_frame_word", fft_in_real, {112'd0, 16'h0100});
        check_start();
        recv_frame(1'b0, 1'b0, fv);
        check_output("imp_latency", 128'(fv - s0), 128'd6);
        check_output("imp_starts", 128'(start_count), 128'd1);

        $display("[TB] input bubbles");
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = 16'(i + 1); tx_imag[i] = 16'h8000 + 16'(i);
            stub_real[i] = 16'h1000 + 16'(i); stub_imag[i] = 16'h2000 + 16'(i);
        end
        send_frame(8, 1'b1, t_last);
        check_output("bub_frame_word", fft_in_real, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check_output("bub_starts_before", 128'(start_count), 128'd1);
        check_start();
        recv_frame(1'b0, 1'b0, fv);
        check_output("bub_starts", 128'(start_count), 128'd2);

        $display("[TB] output backpressure");
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = 16'h0300 + 16'(i); tx_imag[i] = 16'h0400 + 16'(i);
            stub_real[i] = 16'((i + 1) * 16); stub_imag[i] = 16'hF000 + 16'(i);
        end
        send_frame(8, 1'b0, t_last);
        check_start();
        recv_frame(1'b1, 1'b0, fv);

        $display("[TB] timeout");
        stub_en = 1'b0;
        send_frame(8, 1'b0, t_last);
        for (int j = 0; j < 17; j++) begin
            check_output("to_err_low", 128'(timeout_err), 128'd0);
            check_output("to_mvalid", 128'(m_valid), 128'd0);
            tick();
        end
        check_output("to_err_rise", 128'(timeout_err), 128'd1);
        check_output("to_sready", 128'(s_ready), 128'd1);
        tick();
        tick();
        check_output("to_err_sticky", 128'(timeout_err), 128'd1);
        check_output("to_mvalid_after", 128'(m_valid), 128'd0);
        stub_en = 1'b1;
        for (int i = 0; i < 8; i++) stub_real[i] = 16'h5500 + 16'(i);
        send_frame(8, 1'b0, t_last);
        check_start();
        recv_frame(1'b0, 1'b0, fv);
        check_output("to_err_kept", 128'(timeout_err), 128'd1);

        $display("[TB] reset mid-load");
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = 16'hA000 + 16'(i); tx_imag[i] = 16'hB000 + 16'(i);
        end
        s0 = start_count;
        send_frame(5, 1'b0, t_last);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("mid_sready", 128'(s_ready), 128'd1);
        check_output("mid_terr_clr", 128'(timeout_err), 128'd0);
        check_output("mid_frame_clr", fft_in_real, 128'd0);
        tick();
        tick();
        check_output("mid_no_start", 128'(start_count), 128'(s0));
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = 16'hC000 + 16'(i); tx_imag[i] = 16'hD000 + 16'(i);
            stub_real[i] = 16'h0A00 + 16'(i); stub_imag[i] = 16'h0B00 + 16'(i);
        end
        send_frame(8, 1'b0, t_last);
        check_start();
        recv_frame(1'b0, 1'b0, fv);

        $display("[TB] back-to-back frames");
        s0 = start_count;
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = 16'h1100 + 16'(i); tx_imag[i] = 16'h2200 + 16'(i);
            stub_real[i] = 16'h3300 + 16'(i); stub_imag[i] = 16'h4400 + 16'(i);
        end
        send_frame(8, 1'b0, t_last);
        check_start();
        for (int i = 0; i < 8; i++) begin
            tx_real[i] = 16'h6600 + 16'(i); tx_imag[i] = 16'h7700 + 16'(i);
        end
        s_valid = 1'b1;
        s_real  = tx_real[0];
        s_imag  = tx_imag[0];
        recv_frame(1'b0, 1'b1, fv);
        for (int i = 0; i < 8; i++) begin
            stub_real[i] = 16'h8800 + 16'(i); stub_imag[i] = 16'h9900 + 16'(i);
        end
        send_frame(8, 1'b0, t_last);
        check_start();
        recv_frame(1'b0, 1'b0, fv);
        check_output("b2b_starts", 128'(start_count - s0), 128'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
